mac_sequencer: RTL
==================

// Module: mac_sequencer
// PURPOSE
//  Upstream controller/feeder for the 8x8 MAC neuron datapath.
//  - Accepts (input, weight) byte pairs over a valid/ready stream.
//  - Drives the datapath load strobes, accumulates exactly N pairs, then enables activation.
//  - Captures the activated result and offers it on an output valid/ready stream.
//  - Clears the datapath between neurons.
// PARAMETERS
//  N      8                   products per neuron (>=1)
//  ACC_W  16+clog2(N) (=19)   accumulator/activation width; derived, not overridden
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  s_valid     in   1      input pair valid
//  s_ready     out  1      sequencer accepts pair this cycle
//  s_in        in   8      input byte
//  s_weight    in   8      weight byte
//  dp_rst      out  1      datapath reset = rst | (state==CLR)
//  dp_in       out  8      to datapath in (= s_in, combinational)
//  dp_weight   out  8      to datapath inWeight (= s_weight, combinational)
//  ldIn        out  1      load input register
//  ldWeight    out  1      load weight register
//  ldNReg      out  1      load accumulator
//  count_up    out  1      datapath counter increment
//  ready       out  1      activation enable
//  outActive   in   ACC_W  datapath activation output
//  count_cout  in   1      datapath counter carry-out
//  m_valid     out  1      result valid
//  m_ready     in   1      consumer accepts result
//  m_data      out  ACC_W  registered result
//  err         out  1      sticky count mismatch (see CONFIGURATION)
// BEHAVIOUR
//  FSM states:
//   CLR   -> ACC    unconditional; dp_rst=1, pair count cnt=0
//   ACC   -> DRAIN  on the N-th accept
//   DRAIN -> ACT    unconditional
//   ACT   -> OUT    unconditional
//   OUT   -> CLR    on m_valid & m_ready
//  Reset: state=CLR; all outputs 0 except dp_rst=1. m_data=0, err=0.
//  Reset mid-operation: the partial sum is discarded and nothing is emitted.
//  ACC:
//   - s_ready=1 while cnt<N.
//   - Accept cycle (s_valid & s_ready): ldIn=ldWeight=1, cnt++.
//   - Cycle after each accept: ldNReg=count_up=1, via registered acc_pend.
//     Back-to-back accepts overlap: ldNReg of pair k coincides with ldIn of pair k+1.
//   - s_valid gaps are allowed; there is no timeout.
//  DRAIN: s_ready=0; final ldNReg/count_up pulse.
//  ACT:
//   - ready=1.
//   - m_data <= outActive at the end of the cycle.
//  OUT:
//   - m_valid=1; m_data is held stable until m_ready.
//   - ready=0, s_ready=0.
//   - Holds indefinitely under backpressure.
//  Latency: last accept at cycle t -> m_valid at t+3.
//  Throughput: N+4 cycles per neuron with m_ready=1.
//  Arithmetic: the sequencer does none on data; cnt is clog2(N+1) bits and never wraps.
// CONFIGURATION
//  MAC_SEQ_CNT_CHECK_EN defined:
//   - In ACT, err is set (sticky until rst) if count_cout!=1.
//   - In ACC, err is set if count_cout==1 while cnt<N.
//  MAC_SEQ_CNT_CHECK_EN undefined: err tied 0; count_cout ignored.
// STRUCTURE
//  Package mac_pkg:
//   - clog2 function, ACC_W derivation, FSM state encoding (CLR/ACC/DRAIN/ACT/OUT).
//  Sub-module mac_seq_cnt: pair counter with clear, inc, and done (cnt==N).
//  Everything else lives in mac_sequencer.
// TESTING
//  1. N=4; pairs (1,2),(3,4),(5,6),(7,8) back-to-back; m_ready=1
//     -> m_data=100; m_valid at t_last+3; 4 ldNReg pulses.
//  2. Same pairs, s_valid low 3 cycles between each pair
//     -> m_data=100; ldIn/ldNReg only on accept and accept+1.
//  3. Hold m_ready=0 for 5 cycles in OUT
//     -> m_valid and m_data held; s_ready=0; then CLR (dp_rst=1) and a new neuron starts.
//  4. rst for 1 cycle after 2 of 4 pairs; then (1,1)x4
//     -> m_data=4; no m_valid before the second neuron completes.
//  5. Two neurons back-to-back, (2,2)x4 then (3,3)x4
//     -> m_data=16, then 36; dp_rst pulses once between neurons.
//  6. MAC_SEQ_CNT_CHECK_EN; stub holds count_cout=0
//     -> err=1 from ACT onward, cleared only by rst.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC neuron sequencer.
package mac_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator/activation width for n 8x8 products.
    function automatic int unsigned acc_w(input int unsigned n);
        return 16 + clog2(n);
    endfunction

    // Pair counter width: must hold the value n without wrapping.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (clog2(n + 1) == 0) ? 1 : clog2(n + 1);
    endfunction

    typedef enum logic [2:0] {
        CLR   = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        ACT   = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

// File: rtl/mac_seq_cnt.sv
// Pair counter for the sequencer: clears, increments, saturates at N.
module mac_seq_cnt
    import mac_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = cnt_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    assign done = (cnt == CNT_W'(N));

    // Count accepted pairs; holds at N so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Controller/feeder for the 8x8 MAC neuron datapath.
// Optional feature macro: MAC_SEQ_CNT_CHECK_EN (datapath counter cross-check on err).
module mac_sequencer
    import mac_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned ACC_W = acc_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_in,
    input  logic [7:0]       s_weight,
    output logic             dp_rst,
    output logic [7:0]       dp_in,
    output logic [7:0]       dp_weight,
    output logic             ldIn,
    output logic             ldWeight,
    output logic             ldNReg,
    output logic             count_up,
    output logic             ready,
    input  logic [ACC_W-1:0] outActive,
    input  logic             count_cout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic             err
);

    localparam int unsigned CNT_W = cnt_w(N);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             cnt_clr;
    logic             accept;
    logic             acc_pend;

    assign dp_in     = s_in;
    assign dp_weight = s_weight;

    mac_seq_cnt #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (accept),
        .cnt  (cnt),
        .done (cnt_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR;
        end else begin
            state <= state_next;
        end
    end

    // Next state and strobes; everything except dp_rst is held low during rst.
    always_comb begin
        state_next = state;
        dp_rst     = rst || (state == CLR);
        s_ready    = 1'b0;
        accept     = 1'b0;
        cnt_clr    = 1'b0;
        ldIn       = 1'b0;
        ldWeight   = 1'b0;
        ldNReg     = 1'b0;
        count_up   = 1'b0;
        ready      = 1'b0;
        m_valid    = 1'b0;
        if (!rst) begin
            case (state)
                CLR: begin
                    cnt_clr    = 1'b1;
                    state_next = ACC;
                end
                ACC: begin
                    s_ready  = !cnt_done;
                    accept   = s_valid && s_ready;
                    ldIn     = accept;
                    ldWeight = accept;
                    ldNReg   = acc_pend;
                    count_up = acc_pend;
                    if (accept && (cnt == CNT_W'(N - 1))) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    ldNReg     = acc_pend;
                    count_up   = acc_pend;
                    state_next = ACT;
                end
                ACT: begin
                    ready      = 1'b1;
                    state_next = OUT;
                end
                OUT: begin
                    m_valid = 1'b1;
                    if (m_ready) begin
                        state_next = CLR;
                    end
                end
                default: begin
                    state_next = CLR;
                end
            endcase
        end
    end

    // Accumulate strobe trails each accept by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_pend <= 1'b0;
        end else begin
            acc_pend <= accept;
        end
    end

    // Capture the activated result; held through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data <= '0;
        end else if (state == ACT) begin
            m_data <= outActive;
        end
    end

`ifdef MAC_SEQ_CNT_CHECK_EN
    // Sticky flag when the datapath counter disagrees with the pair count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == ACT) && !count_cout) begin
            err <= 1'b1;
        end else if ((state == ACC) && count_cout && !cnt_done) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_count_cout;
    assign unused_count_cout = count_cout;
    assign err               = 1'b0;
`endif

endmodule
